lsu: RTL
========

# lsu

Load/store unit between the execute stage and data memory. Accepts the effective address computed by the ALU for LOAD/STORE instructions, drives a single-outstanding request/acknowledge transaction on the dmem port, and returns aligned, sign- or zero-extended load data to write-back. Holds `stall` high while a transaction is in flight so the core freezes the pipeline.

## Interface
Parameters:
- `TIMEOUT`, default 255: max cycles `dmem_req` stays high without `dmem_ack`. 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ex_valid`  in  1  execute stage presents an instruction
- `ex_ready`  out  1  LSU idle, can accept
- `inst`  in  32  instruction word; opcode [6:0], funct3 [14:12]
- `addr`  in  32  effective address (rs1 + imm from ALU)
- `store_data`  in  32  rs2 value
- `dmem_req`  out  1  request valid
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  word address {addr[31:2],2'b00}
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_ack`  in  1  request completed; `dmem_rdata` valid this cycle
- `dmem_rdata`  in  32  read word
- `done`  out  1  one-cycle pulse, access finished
- `wb_en`  out  1  with `done`: load result valid
- `wb_data`  out  32  extended load data
- `fault`  out  1  one-cycle pulse: misaligned or illegal funct3
- `timeout`  out  1  one-cycle pulse: no ack within TIMEOUT
- `stall`  out  1  high in every non-IDLE state

## Operation
- Accept: in IDLE, `ex_valid` with opcode LOAD (0000011) or STORE (0100011) is captured (inst fields, addr, store_data). Other opcodes ignored; `ex_ready` stays 1.
- Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW. Others are illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- FSM states: IDLE, REQ, RESP, FAULT.
  - IDLE→REQ on legal aligned accept; IDLE→FAULT on illegal/misaligned accept (no dmem request issued).
  - REQ: `dmem_req`=1, outputs stable; on `dmem_ack` capture rdata, →RESP; on counter reaching TIMEOUT (TIMEOUT>0) →IDLE with `timeout` pulse, `dmem_req` dropped.
  - RESP: `done`=1, `wb_en`=1 for loads only; →IDLE.
  - FAULT: `fault`=1; →IDLE.
- Byte enables: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111. Loads drive 1111.
- Store data: SB {4{rs2[7:0]}}; SH {2{rs2[15:0]}}; SW rs2.
- Load extract: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- `dmem_ack` outside REQ ignored. `wb_data` holds last load value; 0 after reset.

## Timing
- Accept at edge 0; `dmem_req` high from cycle 1. Ack in cycle k (k≥1) → `done` in cycle k+1. Minimum latency load/store: 2 cycles accept-to-done.
- Fault: accept at 0, `fault` in cycle 1, `ex_ready` back in cycle 2.
- Timeout counter clears on entering REQ, increments each REQ cycle without ack; ack in the same cycle as counter reaching TIMEOUT wins (completes normally).
- `ex_ready` = (state==IDLE); next accept possible the cycle after `done`/`fault`/`timeout`.
- Reset (any time, including mid-REQ): all outputs 0 immediately (`dmem_req`, `done`, `wb_en`, `fault`, `timeout`, `stall`, `dmem_*`, `wb_data`), `ex_ready` 1 once deasserted, state IDLE, counter 0.

## Structure
- Opcode and funct3 constants come from shared `opcode.vh`; add LSU state encodings and funct3 load/store names to new `lsu.vh`.
- One combinational sub-module `lsu_align`: byte-enable generation, store lane replication, load extraction/extension. FSM, capture registers and timeout counter live in `lsu`.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, ack after 3 req cycles → dmem_addr 0x100, be 1111, done+wb_en cycle 4, wb_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80xxxxxx → wb_data 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102, rdata 0x8001xxxx → 0x00008001.
- SB addr 0x201, rs2 0x123456AB → dmem_we 1, be 0010, wdata 0xABABABAB, done with wb_en 0.
- SW addr 0x302 → no dmem_req, fault pulse cycle 1; load funct3 011 → fault pulse.
- TIMEOUT=4, never ack → req high 4 cycles, timeout pulse, ex_ready returns; rst_n low mid-REQ → dmem_req drops immediately.
- ex_valid with OP opcode (0110011) → no request, ex_ready stays 1, stall stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   - RV32 LOAD/STORE opcodes and funct3 access-size names
//   - lsu_state_e: FSM state encoding
//   - access_legal(): funct3 legality plus natural-alignment check
package lsu_pkg;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StResp  = 2'd2,
    StFault = 2'd3
  } lsu_state_e;

  // True when funct3 names a real access of this kind and addr is naturally aligned for it.
  function automatic logic access_legal(input logic       is_load,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (is_load) begin
      case (funct3)
        F3Lb, F3Lbu: ok = 1'b1;
        F3Lh, F3Lhu: ok = ~addr_lo[0];
        F3Lw:        ok = (addr_lo == 2'b00);
        default:     ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3Sb:    ok = 1'b1;
        F3Sh:    ok = ~addr_lo[0];
        F3Sw:    ok = (addr_lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data alignment for the load/store unit.
//   is_load_i    - access is a load (byte enables forced to 1111)
//   funct3_i     - access size / signedness
//   addr_lo_i    - byte offset within the word
//   store_data_i - rs2 value
//   rdata_i      - word returned by data memory
//   be_o         - byte enables
//   wdata_o      - store data replicated across all lanes of its size
//   load_data_o  - selected lane, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    rd_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    be_o    = 4'b1111;
    wdata_o = store_data_i;
    if (!is_load_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
          wdata_o = {2{store_data_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = store_data_i;
        end
      endcase
    end

    case (funct3_i)
      F3Lb:    load_data_o = {{24{rd_byte[7]}}, rd_byte};
      F3Lh:    load_data_o = {{16{rd_half[15]}}, rd_half};
      F3Lbu:   load_data_o = {24'h0, rd_byte};
      F3Lhu:   load_data_o = {16'h0, rd_half};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and data memory.
// Accepts one LOAD/STORE from execute while idle, runs a single outstanding req/ack
// transaction on the dmem port and returns extended load data to write-back.
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   ex_valid_i/_ready_o  - execute handshake; ready only while idle
//   inst_i, addr_i       - instruction word and effective address
//   store_data_i         - rs2 value
//   dmem_*               - memory request port (held stable while requesting)
//   done_o, wb_en_o      - completion pulse; wb_en_o marks a load result
//   wb_data_o            - most recent load result
//   fault_o, timeout_o   - misaligned/illegal access pulse, missing-ack pulse
//   stall_o              - pipeline freeze while busy
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        done_o,
  output logic        wb_en_o,
  output logic [31:0] wb_data_o,
  output logic        fault_o,
  output logic        timeout_o,
  output logic        stall_o
);

  // Counter counts REQ cycles without ack, 0 .. TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_load_q, is_load_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     store_data_q, store_data_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            timeout_q, timeout_d;

  logic [6:0]  opcode;
  logic        is_load_op;
  logic        is_mem_op;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        in_req;
  logic        unused_inst;

  assign opcode      = inst_i[6:0];
  assign is_load_op  = (opcode == OpcLoad);
  assign is_mem_op   = is_load_op || (opcode == OpcStore);
  assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

  lsu_align u_align (
    .is_load_i    (is_load_q),
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (store_data_q),
    .rdata_i      (dmem_rdata_i),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    wb_data_d    = wb_data_q;
    timeout_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_valid_i && is_mem_op) begin
          is_load_d    = is_load_op;
          funct3_d     = inst_i[14:12];
          addr_d       = addr_i;
          store_data_d = store_data_i;
          cnt_d        = '0;
          state_d      = access_legal(is_load_op, inst_i[14:12], addr_i[1:0]) ? StReq : StFault;
        end
      end
      StReq: begin
        // An ack arriving in the last allowed cycle still completes the access.
        if (dmem_ack_i) begin
          if (is_load_q) begin
            wb_data_d = load_data;
          end
          state_d = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      store_data_q <= '0;
      wb_data_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      wb_data_q    <= wb_data_d;
      timeout_q    <= timeout_d;
    end
  end

  assign in_req = (state_q == StReq);

  // dmem outputs are forced to zero outside REQ so reset clears them immediately.
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req & ~is_load_q;
  assign dmem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_be_o    = in_req ? be : 4'h0;
  assign dmem_wdata_o = in_req ? wdata : 32'h0;

  // ex_ready is held low while reset is asserted.
  assign ex_ready_o = rst_ni && (state_q == StIdle);
  assign stall_o    = (state_q != StIdle);
  assign done_o     = (state_q == StResp);
  assign wb_en_o    = (state_q == StResp) && is_load_q;
  assign wb_data_o  = wb_data_q;
  assign fault_o    = (state_q == StFault);
  assign timeout_o  = timeout_q;

endmodule
